video_arbslot: RTL and testbench
================================

VIDEO_ARBSLOT -- requirements
Module: video_arbslot

Interface
REQ-001 clk  in  1  28 MHz system clock; all logic on rising edge.
REQ-002 rst_n  in  1  reset: asynchronous, active-low.
REQ-003 cbeg, pre_cend, cend  in  1 each  DRAM-cycle phase strobes, one clk wide; cend marks the last clk of each DRAM cycle.
REQ-004 video_go  in  1  video fetch window active.
REQ-005 video_bw  in  2  video bandwidth code.
REQ-006 video_addr  in  21  next video word address.
REQ-007 video_next  out  1  one-clk pulse: video_addr consumed, present next.
REQ-008 video_strobe  out  1  one-clk pulse: video_data from DRAM valid now.
REQ-009 cpu_req  in  1  CPU access pending; held until cpu_next.
REQ-010 cpu_rnw  in  1  CPU direction: 1 = read.
REQ-011 cpu_addr  in  21  CPU word address.
REQ-012 cpu_next  out  1  one-clk pulse: CPU request accepted.
REQ-013 cpu_strobe  out  1  one-clk pulse: CPU read data valid, or write done.
REQ-014 dram_req  out  1  current DRAM cycle is in use.
REQ-015 dram_rnw  out  1  direction of the current DRAM cycle.
REQ-016 dram_addr  out  21  address of the current DRAM cycle.

Function
REQ-017 The block keeps a 3-bit slot counter; it increments by 1 on every cend and wraps from 7 to 0.
- Behaviour is unaffected by video_go.
REQ-018 The block keeps an owner register with states NONE, VIDEO and CPU; the owner changes only on cend.
REQ-019 Video eligibility at cend is video_go AND the slot-counter value (before increment) matches video_bw:
- 00: slot==7 (1/8).
- 01: slot[1:0]==3 (1/4).
- 10: slot[0]==1 (1/2).
- 11: every cycle.
REQ-020 Next owner at cend:
- VIDEO if video is eligible.
- else CPU if cpu_req.
- else NONE.
- Video wins any tie with the CPU.
REQ-021 On the cend that grants VIDEO, video_next pulses for that clk and video_addr is registered into dram_addr, with dram_rnw=1.
REQ-022 On the cend that grants CPU, cpu_next pulses for that clk and cpu_addr and cpu_rnw are registered into dram_addr and dram_rnw.
REQ-023 dram_req=1 whenever the owner is not NONE; dram_addr and dram_rnw hold their values for the whole owned cycle.
REQ-024 Strobe at the cend that ends an owned cycle:
- video_strobe pulses if the owner is VIDEO.
- cpu_strobe pulses if the owner is CPU.
- The strobe for the cycle ending and the grant for the next cycle fall on the same clk.
- Grant-to-strobe latency is exactly one DRAM cycle.
REQ-025 When video_go falls during a VIDEO-owned cycle, that cycle still completes and produces video_strobe; no further video grants occur.
REQ-026 cpu_req deasserting without a cpu_next is legal; the block issues no grant and no strobe for it.
REQ-027 At most one of video_next and cpu_next, and at most one of video_strobe and cpu_strobe, is high in any clk.
REQ-028 When owner is NONE, dram_addr and dram_rnw keep their last values.
REQ-029 cbeg and pre_cend are accepted inputs but do not change state.

Reset
REQ-030 While rst_n=0: slot counter=0, owner=NONE, all pulse outputs=0, dram_req=0, dram_rnw=1, dram_addr=0.
REQ-031 Reset asserted mid-cycle aborts the cycle; no strobe is issued for it.
REQ-032 After rst_n rises, the first grant is made at the first cend.

Verification
REQ-033 Scenario: video_go=1, video_bw=00, cpu_req=0 for 16 cends.
- Required: video_next at slots 7 and 15 only.
- Required: video_strobe on the cend following each video_next.
REQ-034 Scenario: video_bw=01, video_go=1, cpu_req held at 1.
- Required: grant pattern repeats CPU,CPU,CPU,VIDEO.
- Required: cpu_next count is 3 per 4 cends.
REQ-035 Scenario: video_bw=11, cpu_req=1 for 8 cends.
- Required: zero cpu_next (CPU starved).
- Then video_go=0: required cpu_next on the next cend.
REQ-036 Scenario: video_go drops 1 clk after a VIDEO grant.
- Required: video_strobe still pulses at that cycle's cend.
- Required: no further video_next.
REQ-037 Scenario: rst_n pulsed low for 1 clk during a CPU-owned cycle with cpu_addr=0x1ABCD.
- Required: dram_req=0 immediately and dram_addr=0.
- Required: no cpu_strobe for the aborted cycle.
- Required: slot counter restarts at 0.
REQ-038 Scenario: random cpu_req, video_go and video_bw for 10k cycles.
- Required: REQ-027 exclusivity always holds.
- Required: each next pulse is followed by exactly one matching strobe on the next cend.

Source files
------------

// File: rtl/video_arbslot.sv
// video_arbslot: per-DRAM-cycle slot arbiter between the video fetcher and
// the CPU. A 3-bit slot counter advances on every cend. At each cend the
// next cycle's owner is picked: video first, when its bandwidth code selects
// the current slot, otherwise the CPU. The strobe for the cycle that is
// ending is issued on the same cend.
module video_arbslot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cbeg,
    input  logic        pre_cend,
    input  logic        cend,
    input  logic        video_go,
    input  logic [1:0]  video_bw,
    input  logic [20:0] video_addr,
    output logic        video_next,
    output logic        video_strobe,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    output logic        cpu_next,
    output logic        cpu_strobe,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic [20:0] dram_addr
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VIDEO,
        OWN_CPU
    } owner_t;

    logic [2:0] slot;
    owner_t     owner;
    logic       slot_match;
    logic       video_elig;
    logic       cpu_win;

    // cbeg and pre_cend carry DRAM phase information that this arbiter does not need
    logic unused_phase;
    assign unused_phase = cbeg ^ pre_cend;

    // Video slot selection from the bandwidth code, using the pre-increment slot
    always_comb begin
        slot_match = 1'b0;
        case (video_bw)
            2'b00:   slot_match = (slot == 3'd7);
            2'b01:   slot_match = (slot[1:0] == 2'b11);
            2'b10:   slot_match = slot[0];
            default: slot_match = 1'b1;
        endcase
        video_elig = video_go & slot_match;
        cpu_win    = ~video_elig & cpu_req;
    end

    // Grant and strobe pulses must coincide with the cend clk itself, so they
    // are decoded from cend and the registered owner instead of being flopped;
    // gating with rst_n keeps them low while reset is held.
    always_comb begin
        video_next   = rst_n & cend & video_elig;
        cpu_next     = rst_n & cend & cpu_win;
        video_strobe = rst_n & cend & (owner == OWN_VIDEO);
        cpu_strobe   = rst_n & cend & (owner == OWN_CPU);
    end

    // Slot counter, owner and latched DRAM command, all advancing on cend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= '0;
            owner     <= OWN_NONE;
            dram_req  <= 1'b0;
            dram_rnw  <= 1'b1;
            dram_addr <= '0;
        end else if (cend) begin
            slot <= slot + 3'd1;
            if (video_elig) begin
                owner     <= OWN_VIDEO;
                dram_req  <= 1'b1;
                dram_rnw  <= 1'b1;
                dram_addr <= video_addr;
            end else if (cpu_win) begin
                owner     <= OWN_CPU;
                dram_req  <= 1'b1;
                dram_rnw  <= cpu_rnw;
                dram_addr <= cpu_addr;
            end else begin
                owner    <= OWN_NONE;
                dram_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_arbslot.sv
// Self-checking bench for video_arbslot: a slot/owner reference model built
// from the arbitration rules, scenario tasks and a randomized soak.
module tb_video_arbslot;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cbeg = 1'b0, pre_cend = 1'b0, cend = 1'b0;
    logic        video_go = 1'b0;
    logic [1:0]  video_bw = 2'b00;
    logic [20:0] video_addr = '0;
    logic        video_next, video_strobe;
    logic        cpu_req = 1'b0, cpu_rnw = 1'b1;
    logic [20:0] cpu_addr = '0;
    logic        cpu_next, cpu_strobe;
    logic        dram_req, dram_rnw;
    logic [20:0] dram_addr;

    video_arbslot dut (
        .clk(clk), .rst_n(rst_n), .cbeg(cbeg), .pre_cend(pre_cend), .cend(cend),
        .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
        .video_next(video_next), .video_strobe(video_strobe),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .cpu_next(cpu_next), .cpu_strobe(cpu_strobe),
        .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr)
    );

    always #18 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus requested by the scenario tasks, applied at the next negedge
    logic        t_rst_n = 1'b0, t_go = 1'b0, t_req = 1'b0, t_rnw = 1'b1;
    logic [1:0]  t_bw = 2'b00;
    logic [20:0] t_vaddr = '0, t_caddr = '0;
    int          ph = 0;
    int          dlen = 4;
    bit          rand_dlen = 0;

    // reference model: slot number, owner (0 none, 1 video, 2 cpu), command
    int          m_slot;
    int          m_owner;
    logic        m_rnw;
    logic [20:0] m_addr;
    logic [26:0] e_vec;

    function automatic logic [26:0] obs();
        return {video_next, cpu_next, video_strobe, cpu_strobe, dram_req, dram_rnw, dram_addr};
    endfunction

    // video is due when the slot is the last one of its 8/4/2/1-cycle period
    function automatic bit video_due();
        int per;
        per = 8 >> int'(video_bw);
        return video_go && ((m_slot % per) == per - 1);
    endfunction

    task automatic model_reset();
        m_slot = 0; m_owner = 0; m_rnw = 1'b1; m_addr = '0;
    endtask

    task automatic model_expect();
        bit due;
        if (!rst_n) model_reset();
        due = video_due();
        e_vec = {rst_n && cend && due, rst_n && cend && !due && cpu_req,
                 rst_n && cend && m_owner == 1, rst_n && cend && m_owner == 2,
                 m_owner != 0, m_rnw, m_addr};
    endtask

    task automatic model_advance();
        bit due;
        if (rst_n && cend) begin
            due = video_due();
            m_slot = (m_slot + 1) % 8;
            if (due) begin
                m_owner = 1; m_rnw = 1'b1; m_addr = video_addr;
            end else if (cpu_req) begin
                m_owner = 2; m_rnw = cpu_rnw; m_addr = cpu_addr;
            end else begin
                m_owner = 0;
            end
        end
    endtask

    // one clk: commit the previous clk into the model, apply stimulus, predict
    task automatic drive_clk();
        model_advance();
        @(negedge clk);
        rst_n = t_rst_n; video_go = t_go; video_bw = t_bw; video_addr = t_vaddr;
        cpu_req = t_req; cpu_rnw = t_rnw; cpu_addr = t_caddr;
        cbeg = (ph == 0); pre_cend = (ph == dlen - 2); cend = (ph == dlen - 1);
        if (ph == dlen - 1) begin
            ph = 0;
            if (rand_dlen) dlen = $urandom_range(2, 6);
        end else begin
            ph++;
        end
        #1;
        model_expect();
    endtask

    task automatic do_reset();
        t_rst_n = 1'b0; t_go = 1'b0; t_req = 1'b0;
        drive_clk(); drive_clk();
        t_rst_n = 1'b1; ph = 0; dlen = 4;
    endtask

    task automatic test_reset();
        t_rst_n = 1'b0; t_go = 1'b1; t_bw = 2'b11; t_req = 1'b1; t_caddr = 21'h12345;
        for (int i = 0; i < 6; i++) begin
            drive_clk();
            n_tests++;
            if (obs() !== {4'b0000, 1'b0, 1'b1, 21'h0}) begin
                n_fail++;
                $display("FAIL reset_state clk%0d got %h want %h", i, obs(), {4'b0000, 1'b0, 1'b1, 21'h0});
            end
        end
    endtask

    task automatic test_bw_eighth();
        logic [16:0] vn_mask = '0, vs_mask = '0;
        int c = 0;
        do_reset();
        t_go = 1'b1; t_bw = 2'b00; t_req = 1'b0;
        while (c < 17) begin
            t_vaddr = 21'($urandom);
            drive_clk();
            n_tests++;
            if (obs() !== e_vec) begin
                n_fail++;
                $display("FAIL bw00_model t=%0t got %h want %h", $time, obs(), e_vec);
            end
            if (cend) begin
                vn_mask[c] = video_next; vs_mask[c] = video_strobe; c++;
            end
        end
        n_tests++;
        if (vn_mask !== 17'h08080) begin
            n_fail++; $display("FAIL bw00_next_slots got %h want %h", vn_mask, 17'h08080);
        end
        n_tests++;
        if (vs_mask !== 17'h10100) begin
            n_fail++; $display("FAIL bw00_strobe_slots got %h want %h", vs_mask, 17'h10100);
        end
    endtask

    task automatic test_bw_quarter_cpu();
        logic [15:0] vn_mask = '0, cn_mask = '0;
        int c = 0;
        do_reset();
        t_go = 1'b1; t_bw = 2'b01; t_req = 1'b1;
        while (c < 16) begin
            t_rnw = 1'($urandom); t_caddr = 21'($urandom); t_vaddr = 21'($urandom);
            drive_clk();
            n_tests++;
            if (obs() !== e_vec) begin
                n_fail++;
                $display("FAIL bw01_model t=%0t got %h want %h", $time, obs(), e_vec);
            end
            if (cend) begin
                vn_mask[c] = video_next; cn_mask[c] = cpu_next; c++;
            end
        end
        n_tests++;
        if ({vn_mask, cn_mask} !== {16'h8888, 16'h7777}) begin
            n_fail++;
            $display("FAIL bw01_pattern got v=%h c=%h want v=8888 c=7777", vn_mask, cn_mask);
        end
    endtask

    task automatic test_starve();
        int cpu_cnt = 0, c = 0;
        do_reset();
        t_go = 1'b1; t_bw = 2'b11; t_req = 1'b1; t_caddr = 21'h0F0F0; t_rnw = 1'b1;
        while (c < 8) begin
            drive_clk();
            if (cpu_next) cpu_cnt++;
            if (cend) c++;
        end
        n_tests++;
        if (cpu_cnt !== 0) begin
            n_fail++; $display("FAIL starve_cpu_next got %0d want 0", cpu_cnt);
        end
        t_go = 1'b0;
        c = 0;
        while (c < 1) begin
            drive_clk();
            if (cend) begin
                c++;
                n_tests++;
                if ({cpu_next, video_next} !== 2'b10) begin
                    n_fail++; $display("FAIL starve_release got %b want 10", {cpu_next, video_next});
                end
            end
        end
    endtask

    task automatic test_go_drop();
        bit found = 0;
        int vs = 0, vn = 0, c = 0;
        do_reset();
        t_go = 1'b1; t_bw = 2'b10; t_req = 1'b0; t_vaddr = 21'h0AAAA;
        for (int i = 0; i < 40; i++) begin
            drive_clk();
            if (video_next) begin found = 1; break; end
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL go_drop_grant got none want video_next within 40 clks");
        end
        t_go = 1'b0;
        while (c < 3) begin
            drive_clk();
            n_tests++;
            if (obs() !== e_vec) begin
                n_fail++;
                $display("FAIL go_drop_model t=%0t got %h want %h", $time, obs(), e_vec);
            end
            if (video_strobe) vs++;
            if (video_next) vn++;
            if (cend) c++;
        end
        n_tests++;
        if (vs !== 1 || vn !== 0) begin
            n_fail++; $display("FAIL go_drop_tail got strobes=%0d nexts=%0d want 1 and 0", vs, vn);
        end
    endtask

    task automatic test_reset_abort();
        bit found = 0;
        int cs = 0, c = 0;
        logic [8:0] vn_mask = '0;
        do_reset();
        t_go = 1'b0; t_req = 1'b1; t_rnw = 1'b0; t_caddr = 21'h1ABCD;
        for (int i = 0; i < 20; i++) begin
            drive_clk();
            if (cpu_next) begin found = 1; break; end
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL abort_grant got none want cpu_next within 20 clks");
        end
        t_req = 1'b0;
        drive_clk();
        n_tests++;
        if ({dram_req, dram_rnw, dram_addr} !== {1'b1, 1'b0, 21'h1ABCD}) begin
            n_fail++;
            $display("FAIL abort_owned got %h want %h", {dram_req, dram_rnw, dram_addr}, {1'b1, 1'b0, 21'h1ABCD});
        end
        t_rst_n = 1'b0;
        drive_clk();
        n_tests++;
        if ({dram_req, dram_addr} !== {1'b0, 21'h0}) begin
            n_fail++; $display("FAIL abort_reset_now got %h want %h", {dram_req, dram_addr}, {1'b0, 21'h0});
        end
        t_rst_n = 1'b1; t_go = 1'b1; t_bw = 2'b00;
        while (c < 9) begin
            drive_clk();
            n_tests++;
            if (obs() !== e_vec) begin
                n_fail++;
                $display("FAIL abort_model t=%0t got %h want %h", $time, obs(), e_vec);
            end
            if (cpu_strobe) cs++;
            if (cend) begin vn_mask[c] = video_next; c++; end
        end
        n_tests++;
        if (cs !== 0 || vn_mask !== 9'h080) begin
            n_fail++; $display("FAIL abort_after got cpu_strobes=%0d vnext=%h want 0 and 080", cs, vn_mask);
        end
    endtask

    task automatic test_random();
        int pend = 0;
        do_reset();
        rand_dlen = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) t_go = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) t_bw = 2'($urandom);
            if ($urandom_range(0, 3) == 0) t_req = 1'($urandom);
            t_rnw = 1'($urandom); t_vaddr = 21'($urandom); t_caddr = 21'($urandom);
            drive_clk();
            n_tests++;
            if (obs() !== e_vec) begin
                n_fail++;
                $display("FAIL rand_model t=%0t got %h want %h", $time, obs(), e_vec);
            end
            n_tests++;
            if ((video_next && cpu_next) || (video_strobe && cpu_strobe)) begin
                n_fail++;
                $display("FAIL rand_exclusive t=%0t got next=%b%b strobe=%b%b want at most one",
                         $time, video_next, cpu_next, video_strobe, cpu_strobe);
            end
            if (cend) begin
                n_tests++;
                if ({video_strobe, cpu_strobe} !== {pend == 1, pend == 2}) begin
                    n_fail++;
                    $display("FAIL rand_strobe_pairing t=%0t got %b%b want %b%b", $time,
                             video_strobe, cpu_strobe, pend == 1, pend == 2);
                end
                pend = video_next ? 1 : (cpu_next ? 2 : 0);
            end
        end
        rand_dlen = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bw_eighth();
        test_bw_quarter_cpu();
        test_starve();
        test_go_drop();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
